// File: rtl/ak4619_adc_deser.sv
// ---------------------------------------------------------------------------
// ak4619_adc_deser
//
// Deserialises the AK4619 ADC serial output (SDOUT1) into parallel signed PCM
// samples in the 12 MHz system domain. BICK and LRCK are the pin-level clocks
// that the top level already generates for the DAC path. They are
// oversampled here, not used as clocks. One left/right pair is presented per
// LRCK frame, together with a single-cycle strobe.
//
// Parameters
//   W          sample width in bits (MSB first, two's complement)
//   I2S_DELAY  BICK rising edges (0 or 1) ignored after each LRCK transition
//
// Ports
//   clk          in   system clock (12 MHz)
//   rst_n        in   asynchronous active-low reset
//   bick         in   bit clock, pin level
//   lrck         in   frame clock, low = left slot, high = right slot
//   sdout        in   codec serial data, changes on BICK falling edge
//   err_clr      in   one-cycle pulse clearing err
//   sample_l     out  last complete left sample
//   sample_r     out  last complete right sample
//   frame_valid  out  one-cycle strobe, samples updated this cycle
//   err          out  sticky framing error (short slot)
// ---------------------------------------------------------------------------
module ak4619_adc_deser #(
    parameter int W         = 16,
    parameter int I2S_DELAY = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bick,
    input  logic         lrck,
    input  logic         sdout,
    input  logic         err_clr,
    output logic [W-1:0] sample_l,
    output logic [W-1:0] sample_r,
    output logic         frame_valid,
    output logic         err
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam bit USE_SKIP = (I2S_DELAY != 0);

    localparam logic [1:0] ST_ALIGN = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Synchroniser chains. All three inputs see the same depth so that data
    // stays aligned with the BICK edge it was launched against. The third
    // stage on bick/lrck exists only for edge detection.
    logic bick_s1, bick_s2, bick_s3;
    logic lrck_s1, lrck_s2, lrck_s3;
    logic sdout_s1, sdout_s2;

    logic bick_rise;
    logic lr_edge;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shift_reg;
    logic [W-1:0]  hold_l;
    logic          hold_valid;
    logic          slot_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bick_s1  <= 1'b0;
            bick_s2  <= 1'b0;
            bick_s3  <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            lrck_s3  <= 1'b0;
            sdout_s1 <= 1'b0;
            sdout_s2 <= 1'b0;
        end else begin
            bick_s1  <= bick;
            bick_s2  <= bick_s1;
            bick_s3  <= bick_s2;
            lrck_s1  <= lrck;
            lrck_s2  <= lrck_s1;
            lrck_s3  <= lrck_s2;
            sdout_s1 <= sdout;
            sdout_s2 <= sdout_s1;
        end
    end

    assign bick_rise = bick_s2 & ~bick_s3;
    assign lr_edge   = lrck_s2 ^ lrck_s3;

    // Framing FSM.
    // An LRCK edge takes priority over everything else. In ALIGN only a
    // falling edge (start of a left slot) is accepted, so a frame never
    // starts with a right slot. The completion check runs one cycle after
    // the last bit was shifted in, which gives the output-register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ALIGN;
            cnt         <= '0;
            shift_reg   <= '0;
            hold_l      <= '0;
            hold_valid  <= 1'b0;
            slot_right  <= 1'b0;
            sample_l    <= '0;
            sample_r    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            // A later assignment in this block (error set) overrides this
            // one, so set wins over clear in the same cycle.
            if (err_clr) begin
                err <= 1'b0;
            end

            if (lr_edge && (state != ST_ALIGN || !lrck_s2)) begin
                // Slot ended before all W bits arrived: flag it and drop any
                // left sample waiting for its right partner.
                if ((state == ST_SHIFT || state == ST_SKIP) && cnt < CNT_FULL) begin
                    err        <= 1'b1;
                    hold_valid <= 1'b0;
                end

                // A new left slot starts a new frame.
                if (!lrck_s2) begin
                    hold_valid <= 1'b0;
                end

                slot_right <= lrck_s2;

                // A BICK rise coinciding with the LRCK edge belongs to the
                // new slot: it is either bit 0 or the discarded delay edge.
                if (USE_SKIP) begin
                    cnt   <= '0;
                    state <= bick_rise ? ST_SHIFT : ST_SKIP;
                end else begin
                    state <= ST_SHIFT;
                    if (bick_rise) begin
                        shift_reg <= {shift_reg[W-2:0], sdout_s2};
                        cnt       <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
            end else begin
                case (state)
                    ST_ALIGN: begin
                    end

                    ST_SKIP: begin
                        if (bick_rise) begin
                            state <= ST_SHIFT;
                        end
                    end

                    ST_SHIFT: begin
                        if (cnt == CNT_FULL) begin
                            state <= ST_DONE;
                            if (!slot_right) begin
                                hold_l     <= shift_reg;
                                hold_valid <= 1'b1;
                            end else begin
                                hold_valid <= 1'b0;
                                if (hold_valid) begin
                                    sample_l    <= hold_l;
                                    sample_r    <= shift_reg;
                                    frame_valid <= 1'b1;
                                end
                            end
                        end else if (bick_rise) begin
                            shift_reg <= {shift_reg[W-2:0], sdout_s2};
                            cnt       <= cnt + CW'(1);
                        end
                    end

                    ST_DONE: begin
                    end

                    default: begin
                        state <= ST_ALIGN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ak4619_adc_deser.sv
// ---------------------------------------------------------------------------
// tb_ak4619_adc_deser
//
// Directed bench for ak4619_adc_deser. Two instances share BICK/LRCK/reset:
// dut0 uses I2S_DELAY=0 and dut1 uses I2S_DELAY=1. Each instance gets its
// own SDOUT stream from the codec model. BICK = clk/4 and a nominal slot is
// 32 BICK periods long. LRCK and SDOUT change on the BICK falling edge.
// ---------------------------------------------------------------------------
module tb_ak4619_adc_deser;

    logic        clk;
    logic        rst_n;
    logic        bick;
    logic        lrck;
    logic        sdout0;
    logic        sdout1;
    logic        err_clr;

    logic [15:0] sample_l0, sample_r0, sample_l1, sample_r1;
    logic        fv0, fv1, err0, err1;

    int checks;
    int errors;
    int cyc;
    int fv0_cnt, fv1_cnt;
    int fv0_last, fv0_prev;
    int rise_cyc;
    int base0, base1;

    ak4619_adc_deser #(.W(16), .I2S_DELAY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bick(bick), .lrck(lrck), .sdout(sdout0),
        .err_clr(err_clr), .sample_l(sample_l0), .sample_r(sample_r0),
        .frame_valid(fv0), .err(err0)
    );

    ak4619_adc_deser #(.W(16), .I2S_DELAY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bick(bick), .lrck(lrck), .sdout(sdout1),
        .err_clr(err_clr), .sample_l(sample_l1), .sample_r(sample_r1),
        .frame_valid(fv1), .err(err1)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running posedge counter used for latency and strobe spacing
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled 1 ns after each rising edge
    initial begin
        fv0_cnt  = 0;
        fv1_cnt  = 0;
        fv0_last = -1000;
        fv0_prev = -1000;
    end

    always @(posedge clk) begin
        #1;
        if (fv0 === 1'b1) begin
            fv0_cnt++;
            fv0_prev = fv0_last;
            fv0_last = cyc;
        end
        if (fv1 === 1'b1) begin
            fv1_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Codec model: one slot of nper BICK periods. dut0 gets the MSB on the
    // first BICK period, dut1 on the second. The BICK rise carrying the dut0
    // right-slot LSB is timestamped for the latency check.
    task automatic applyStimulus(input logic lr, input logic [15:0] val, input int nper);
        for (int p = 0; p < nper; p++) begin
            @(negedge clk);
            bick = 1'b0;
            if (p == 0) lrck = lr;
            sdout0 = (p < 16) ? val[15 - p] : 1'b0;
            sdout1 = (p >= 1 && p <= 16) ? val[16 - p] : 1'b0;
            @(negedge clk);
            @(negedge clk);
            bick = 1'b1;
            if (lr && p == 15) rise_cyc = cyc;
            @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
        applyStimulus(1'b0, l, 32);
        applyStimulus(1'b1, r, 32);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rise_cyc = -2000;
        rst_n    = 1'b0;
        bick     = 1'b0;
        lrck     = 1'b1;
        sdout0   = 1'b0;
        sdout1   = 1'b0;
        err_clr  = 1'b0;
        $display("[TB] start");

        // Reset state
        repeat (4) @(negedge clk);
        checkOutput("reset_sample_l", 32'(sample_l0), 32'h0);
        checkOutput("reset_sample_r", 32'(sample_r0), 32'h0);
        checkOutput("reset_fv", 32'(fv0), 32'h0);
        checkOutput("reset_err", 32'(err0), 32'h0);

        // Alignment: release in the middle of a right slot
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, 20);
        checkOutput("align_no_strobe", 32'(fv0_cnt + fv1_cnt), 32'd0);

        // Basic frame and latency
        sendFrame(16'h8001, 16'h7FFE);
        checkOutput("basic_strobes", 32'(fv0_cnt), 32'd1);
        checkOutput("basic_sample_l", 32'(sample_l0), 32'h8001);
        checkOutput("basic_sample_r", 32'(sample_r0), 32'h7FFE);
        checkOutput("basic_err", 32'(err0), 32'h0);
        checkOutput("latency", 32'(fv0_last - rise_cyc), 32'd4);
        checkOutput("dly1_basic_l", 32'(sample_l1), 32'h8001);
        checkOutput("dly1_basic_r", 32'(sample_r1), 32'h7FFE);

        // Back-to-back frame: one strobe per 256 cycles
        sendFrame(16'h8001, 16'h7FFE);
        checkOutput("basic_strobes2", 32'(fv0_cnt), 32'd2);
        checkOutput("strobe_period", 32'(fv0_last - fv0_prev), 32'd256);

        // Delayed format
        sendFrame(16'h1234, 16'hABCD);
        checkOutput("dly1_sample_l", 32'(sample_l1), 32'h1234);
        checkOutput("dly1_sample_r", 32'(sample_r1), 32'hABCD);
        checkOutput("dly1_strobes", 32'(fv1_cnt), 32'd3);
        checkOutput("dly0_sample_l", 32'(sample_l0), 32'h1234);
        checkOutput("dly0_sample_r", 32'(sample_r0), 32'hABCD);

        // Short left slot (10 periods)
        base0 = fv0_cnt;
        base1 = fv1_cnt;
        applyStimulus(1'b0, 16'h1111, 10);
        applyStimulus(1'b1, 16'h2222, 32);
        checkOutput("short_err0", 32'(err0), 32'h1);
        checkOutput("short_err1", 32'(err1), 32'h1);
        checkOutput("short_no_strobe0", 32'(fv0_cnt - base0), 32'd0);
        checkOutput("short_no_strobe1", 32'(fv1_cnt - base1), 32'd0);
        checkOutput("short_hold_l", 32'(sample_l0), 32'h1234);
        checkOutput("short_hold_r", 32'(sample_r0), 32'hABCD);

        sendFrame(16'h5A5A, 16'hA5A5);
        checkOutput("recover_strobe", 32'(fv0_cnt - base0), 32'd1);
        checkOutput("recover_sample_l", 32'(sample_l0), 32'h5A5A);
        checkOutput("recover_sample_r", 32'(sample_r0), 32'hA5A5);
        checkOutput("err_sticky", 32'(err0), 32'h1);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_clr0", 32'(err0), 32'h0);
        checkOutput("err_clr1", 32'(err1), 32'h0);

        // Reset at bit 7 of a right slot
        applyStimulus(1'b0, 16'h0F0F, 32);
        applyStimulus(1'b1, 16'hF0F0, 8);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_sample_l", 32'(sample_l0), 32'h0);
        checkOutput("midrst_sample_r", 32'(sample_r0), 32'h0);
        checkOutput("midrst_fv", 32'(fv0), 32'h0);
        checkOutput("midrst_err", 32'(err0), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base0 = fv0_cnt;
        applyStimulus(1'b1, 16'hF0F0, 24);
        checkOutput("midrst_no_strobe", 32'(fv0_cnt - base0), 32'd0);
        sendFrame(16'h0001, 16'hFFFF);
        checkOutput("midrst_strobe", 32'(fv0_cnt - base0), 32'd1);
        checkOutput("midrst_new_l", 32'(sample_l0), 32'h0001);
        checkOutput("midrst_new_r", 32'(sample_r0), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
